// File: rtl/mem_stage_data_ram_pkg.sv
// Shared definitions for the data-memory stage: FSM encodings, access
// size / direction codes and the default storage depth.
package mem_stage_data_ram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic SIZE_WORD = 1'b0;
    localparam logic SIZE_BYTE = 1'b1;
    localparam logic RW_LOAD   = 1'b0;
    localparam logic RW_STORE  = 1'b1;

    localparam int MEM_DEPTH = 256;

endpackage

// File: rtl/mem_stage_data_ram_byte_ram.sv
// Byte-wide single-port storage: synchronous write, asynchronous read.
// Contents survive reset; the array is named Mem so it can be preloaded.
module byte_ram
    import mem_stage_data_ram_pkg::*;
#(
    parameter int DEPTH = MEM_DEPTH
) (
    input  logic       i_clk,
    input  logic       i_we,
    input  logic [7:0] i_addr,
    input  logic [7:0] i_wdata,
    output logic [7:0] o_rdata
);

    logic [7:0] Mem [0:DEPTH-1];

    // Write the addressed byte on the rising edge when enabled.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            Mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = Mem[i_addr];

endmodule

// File: rtl/mem_stage_data_ram.sv
// Data-memory stage: sequences a byte or big-endian word access over a
// byte-wide RAM, one byte per cycle, stalling the pipeline until done.
// Optional feature macro: MEM_ALIGN_CHECK_EN (misaligned word accesses
// are rejected with a Fault pulse instead of being performed).
//
// Handshake: a request is taken when E=1 in IDLE; operands are latched
// then, so later changes on A/DI are ignored. Stall = E && state!=DONE,
// so the upstream registers advance on the DONE edge and the next
// request is presented in the following IDLE cycle.
module mem_stage_data_ram
    import mem_stage_data_ram_pkg::*;
#(
    parameter int DEPTH = MEM_DEPTH
) (
    input  logic        Clk,
    input  logic        Clr,
    input  logic        E,
    input  logic        RW,
    input  logic        size,
    input  logic [31:0] A,
    input  logic [31:0] DI,
    output logic [31:0] DO,
    output logic        Stall,
    output logic        Done,
    output logic        Fault,
    output logic [1:0]  o_dbg_state
);

    state_t      r_state;
    state_t      w_next_state;
    logic [1:0]  r_cnt;
    logic [7:0]  r_base;
    logic [31:0] r_data;
    logic        r_size;
    logic        r_rw;
    logic [23:0] r_stage;
    logic [31:0] r_do;

    logic [7:0]  w_addr;
    logic [7:0]  w_rdata;
    logic [7:0]  w_wdata;
    logic        w_we;
    logic        w_last;
    logic        w_unused_addr;

    // Upper address bits select nothing in a 256-byte space.
    assign w_unused_addr = ^A[31:8];

    // Byte address wraps naturally in 8 bits.
    assign w_addr = r_base + {6'd0, r_cnt};
    assign w_last = (r_size == SIZE_BYTE) || (r_cnt == 2'd3);
    // Clr cancels the write of the cycle it lands in.
    assign w_we   = (r_state == ST_XFER) && (r_rw == RW_STORE) && !Clr;

`ifdef MEM_ALIGN_CHECK_EN
    logic w_misalign;
    logic r_fault;

    assign w_misalign = E && (size == SIZE_WORD) && (A[1:0] != 2'b00);

    // Fault is raised only for the DONE cycle of a rejected access.
    always_ff @(posedge Clk) begin
        if (Clr) begin
            r_fault <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            r_fault <= w_misalign;
        end else begin
            r_fault <= 1'b0;
        end
    end

    assign Fault = r_fault;
`else
    assign Fault = 1'b0;
`endif

    // Select the store byte: most significant first for words.
    always_comb begin
        w_wdata = r_data[7:0];
        if (r_size == SIZE_WORD) begin
            case (r_cnt)
                2'd0:    w_wdata = r_data[31:24];
                2'd1:    w_wdata = r_data[23:16];
                2'd2:    w_wdata = r_data[15:8];
                default: w_wdata = r_data[7:0];
            endcase
        end
    end

    // Next-state logic for the IDLE -> XFER -> DONE sequence.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (E) begin
`ifdef MEM_ALIGN_CHECK_EN
                    w_next_state = w_misalign ? ST_DONE : ST_XFER;
`else
                    w_next_state = ST_XFER;
`endif
                end
            end
            ST_XFER: begin
                if (w_last) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // State, operand latches, byte counter, load staging and result.
    always_ff @(posedge Clk) begin
        if (Clr) begin
            r_state <= ST_IDLE;
            r_cnt   <= 2'd0;
            r_base  <= 8'd0;
            r_data  <= 32'd0;
            r_size  <= SIZE_WORD;
            r_rw    <= RW_LOAD;
            r_stage <= 24'd0;
            r_do    <= 32'd0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                ST_IDLE: begin
                    if (E) begin
                        r_base <= A[7:0];
                        r_data <= DI;
                        r_size <= size;
                        r_rw   <= RW;
                        r_cnt  <= 2'd0;
                    end
                end
                ST_XFER: begin
                    r_cnt <= r_cnt + 2'd1;
                    if (r_rw == RW_LOAD) begin
                        r_stage <= {r_stage[15:0], w_rdata};
                        if (w_last) begin
                            r_do <= (r_size == SIZE_BYTE) ? {24'd0, w_rdata}
                                                          : {r_stage, w_rdata};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign DO          = r_do;
    assign Done        = (r_state == ST_DONE);
    assign Stall       = E && (r_state != ST_DONE);
    assign o_dbg_state = r_state;

    byte_ram #(.DEPTH(DEPTH)) u_ram (
        .i_clk   (Clk),
        .i_we    (w_we),
        .i_addr  (w_addr),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata)
    );

endmodule

// File: tb/tb_mem_stage_data_ram.sv
// Bench for mem_stage_data_ram: directed cases plus random accesses,
// checked against a byte-array model through an expected-result queue.
module tb_mem_stage_data_ram;
    import mem_stage_data_ram_pkg::*;

    logic        Clk = 1'b0;
    logic        Clr;
    logic        E;
    logic        RW;
    logic        size;
    logic [31:0] A;
    logic [31:0] DI;
    logic [31:0] DO;
    logic        Stall;
    logic        Done;
    logic        Fault;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]  model_mem [0:255];
    logic [31:0] model_do;
    logic [32:0] exp_q[$];

    // Clock / reset
    always #5 Clk = ~Clk;

    mem_stage_data_ram u_dut (
        .Clk         (Clk),
        .Clr         (Clr),
        .E           (E),
        .RW          (RW),
        .size        (size),
        .A           (A),
        .DI          (DI),
        .DO          (DO),
        .Stall       (Stall),
        .Done        (Done),
        .Fault       (Fault),
        .o_dbg_state (dbg_state)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model: big-endian read with 8-bit address wrap.
    function automatic logic [31:0] model_read(input logic sz, input logic [7:0] b);
        logic [7:0] a1, a2, a3;
        a1 = b + 8'd1;
        a2 = b + 8'd2;
        a3 = b + 8'd3;
        if (sz == SIZE_BYTE) return {24'd0, model_mem[b]};
        return {model_mem[b], model_mem[a1], model_mem[a2], model_mem[a3]};
    endfunction

    // Update the model for one access; return expected stall length.
    function automatic int model_access(input logic rw, input logic sz,
                                        input logic [31:0] addr, input logic [31:0] data);
        logic [7:0] b;
        logic       flt;
        b   = addr[7:0];
        flt = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        if (sz == SIZE_WORD && addr[1:0] != 2'b00) flt = 1'b1;
`endif
        if (!flt) begin
            if (rw == RW_STORE) begin
                if (sz == SIZE_BYTE) model_mem[b] = data[7:0];
                else begin
                    for (int k = 0; k < 4; k++) model_mem[8'(b + k)] = data[31-8*k -: 8];
                end
            end else begin
                model_do = model_read(sz, b);
            end
        end
        exp_q.push_back({flt, model_do});
        if (flt) return 1;
        return (sz == SIZE_BYTE) ? 2 : 5;
    endfunction

    // Driver: present one request and measure how long Stall is held.
    task automatic do_access(input logic rw, input logic sz,
                             input logic [31:0] addr, input logic [31:0] data);
        int exp_stall;
        int n;
        exp_stall = model_access(rw, sz, addr, data);
        @(negedge Clk);
        E = 1'b1; RW = rw; size = sz; A = addr; DI = data;
        #1;
        n = 0;
        while (Stall && n < 20) begin
            n++;
            @(negedge Clk);
            #1;
        end
        if (n >= 20) begin
            n_checks++;
            $display("FAIL stall_timeout: stall still high after %0d cycles, required %0d", n, exp_stall);
        end else begin
            check("stall_len", 64'(n), 64'(exp_stall));
        end
        E = 1'b0;
        A = $urandom; DI = $urandom;
    endtask

    // Monitor: compare DO / Fault with the queue on every Done pulse.
    always @(negedge Clk) begin
        logic [32:0] e;
        if (Done) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_done: Done=1 with empty expected queue, DO=%0h", DO);
            end else begin
                e = exp_q.pop_front();
                check("do_value", 64'(DO), 64'(e[31:0]));
                check("fault", 64'(Fault), 64'(e[32]));
            end
        end
    end

    initial begin
        logic [7:0] old_fe, old_ff, old_00, old_01, old_22, old_23;
        int t1, t2, bad, wait_n;

        Clr = 1'b1; E = 1'b0; RW = 1'b0; size = 1'b0; A = '0; DI = '0;
        model_do = '0;
        for (int i = 0; i < 256; i++) begin
            model_mem[i] = 8'($urandom_range(0, 255));
            u_dut.u_ram.Mem[i] = model_mem[i];
        end
        model_mem[8] = 8'h11; model_mem[9] = 8'h22; model_mem[10] = 8'h33; model_mem[11] = 8'h44;
        for (int i = 8; i < 12; i++) u_dut.u_ram.Mem[i] = model_mem[i];

        repeat (2) @(negedge Clk);
        Clr = 1'b0;

        // Reset state and idle cycles
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            check("idle_do", 64'(DO), 64'h0);
            check("idle_stall", 64'(Stall), 64'h0);
            check("idle_done", 64'(Done), 64'h0);
            check("idle_fault", 64'(Fault), 64'h0);
            check("idle_state", 64'(dbg_state), 64'(ST_IDLE));
        end

        // Word load of preloaded bytes
        do_access(RW_LOAD, SIZE_WORD, 32'd8, 32'h0);

        // Word store then byte load from inside it
        do_access(RW_STORE, SIZE_WORD, 32'h0000_0110, 32'hDEAD_BEEF);
        do_access(RW_LOAD, SIZE_BYTE, 32'h12, 32'h0);
        check("mem_10", 64'(u_dut.u_ram.Mem[8'h10]), 64'hDE);
        check("mem_11", 64'(u_dut.u_ram.Mem[8'h11]), 64'hAD);
        check("mem_12", 64'(u_dut.u_ram.Mem[8'h12]), 64'hBE);
        check("mem_13", 64'(u_dut.u_ram.Mem[8'h13]), 64'hEF);

        // Misaligned word store across the 255 -> 0 wrap
        old_fe = model_mem[8'hFE]; old_ff = model_mem[8'hFF];
        old_00 = model_mem[8'h00]; old_01 = model_mem[8'h01];
        do_access(RW_STORE, SIZE_WORD, 32'hFE, 32'h0102_0304);
`ifdef MEM_ALIGN_CHECK_EN
        check("wrap_fe", 64'(u_dut.u_ram.Mem[8'hFE]), 64'(old_fe));
        check("wrap_ff", 64'(u_dut.u_ram.Mem[8'hFF]), 64'(old_ff));
        check("wrap_00", 64'(u_dut.u_ram.Mem[8'h00]), 64'(old_00));
        check("wrap_01", 64'(u_dut.u_ram.Mem[8'h01]), 64'(old_01));
`else
        check("wrap_fe", 64'(u_dut.u_ram.Mem[8'hFE]), 64'h01);
        check("wrap_ff", 64'(u_dut.u_ram.Mem[8'hFF]), 64'h02);
        check("wrap_00", 64'(u_dut.u_ram.Mem[8'h00]), 64'h03);
        check("wrap_01", 64'(u_dut.u_ram.Mem[8'h01]), 64'h04);
`endif
        do_access(RW_LOAD, SIZE_WORD, 32'hFE, 32'h0);

        // Clr during the third XFER cycle of a word store
        old_22 = model_mem[8'h22]; old_23 = model_mem[8'h23];
        @(negedge Clk);
        E = 1'b1; RW = RW_STORE; size = SIZE_WORD; A = 32'h20; DI = 32'hCAFE_F00D;
        @(negedge Clk);
        A = 32'h80; DI = 32'h0;
        @(negedge Clk);
        @(negedge Clk);
        Clr = 1'b1; E = 1'b0;
        @(negedge Clk);
        Clr = 1'b0;
        model_mem[8'h20] = 8'hCA; model_mem[8'h21] = 8'hFE; model_do = 32'h0;
        #1;
        check("clr_state", 64'(dbg_state), 64'(ST_IDLE));
        check("clr_do", 64'(DO), 64'h0);
        check("clr_done", 64'(Done), 64'h0);
        check("clr_mem_20", 64'(u_dut.u_ram.Mem[8'h20]), 64'hCA);
        check("clr_mem_21", 64'(u_dut.u_ram.Mem[8'h21]), 64'hFE);
        check("clr_mem_22", 64'(u_dut.u_ram.Mem[8'h22]), 64'(old_22));
        check("clr_mem_23", 64'(u_dut.u_ram.Mem[8'h23]), 64'(old_23));

        // Back-to-back byte loads with E held high
        void'(model_access(RW_LOAD, SIZE_BYTE, 32'h10, 32'h0));
        void'(model_access(RW_LOAD, SIZE_BYTE, 32'h13, 32'h0));
        @(negedge Clk);
        E = 1'b1; RW = RW_LOAD; size = SIZE_BYTE; A = 32'h10; DI = 32'h0;
        #1;
        t1 = -1; t2 = -1;
        for (int k = 0; k < 12; k++) begin
            if (Done) begin
                if (t1 < 0) begin
                    t1 = k;
                    A = 32'h13;
                end else if (t2 < 0) begin
                    t2 = k;
                    E = 1'b0;
                end
            end
            if (t2 >= 0) break;
            @(negedge Clk);
            #1;
        end
        E = 1'b0;
        check("b2b_first_done", 64'(t1), 64'd2);
        check("b2b_gap", 64'(t2 - t1), 64'd3);

        // Random accesses
        for (int i = 0; i < 40; i++) begin
            do_access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
        end

        // Drain and final memory comparison
        wait_n = 0;
        while (exp_q.size() != 0 && wait_n < 20) begin
            @(negedge Clk);
            wait_n++;
        end
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            if (u_dut.u_ram.Mem[i] !== model_mem[i]) bad++;
        end
        check("mem_image_bad_bytes", 64'(bad), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_stage_data_ram.md
# mem_stage_data_ram

Data-memory stage of the pipelined ARM datapath. It sits directly downstream of the EX/MEM pipeline register and consumes its address, store data, size, RW and enable outputs. Its read data feeds the MEM/WB register. The memory is 256 bytes, byte-wide and single-port, big-endian like the instruction ROM. A word access takes four byte cycles, so the block raises `Stall` to freeze the upstream pipeline registers until the access completes.

## Interface
Parameters:
- `DEPTH`, default 256: bytes of storage, addressed by `A[7:0]`.

Ports:
- `Clk` in 1: clock, rising-edge.
- `Clr` in 1: one clock; reset is synchronous and active-high.
- `E` in 1: memory access request (MEM_E).
- `RW` in 1: 1 = store, 0 = load (MEM_RW).
- `size` in 1: 1 = byte, 0 = word (MEM_Size).
- `A` in 32: byte address; bits 31:8 are ignored.
- `DI` in 32: store data (Data_Mem_Out).
- `DO` out 32: load result, registered.
- `Stall` out 1: hold the PC, IF/ID, ID/EX and EX/MEM registers.
- `Done` out 1: one-cycle completion pulse.
- `Fault` out 1: misaligned-word pulse. Exists in every build; see Configuration.

## Operation
- Storage array `Mem[0:DEPTH-1]` of 8-bit bytes. `Clr` does not clear it. The bench preloads it hierarchically.
- Byte order is big-endian. A word at base `b` is `Mem[b]` = bits 31:24 through `Mem[b+3]` = bits 7:0.
- FSM states: IDLE, XFER, DONE. There is a 2-bit byte counter `cnt`.
- IDLE:
  - With `E`=1 at a rising edge: latch `A[7:0]`, `DI`, `size` and `RW`; set `cnt`=0; go to XFER.
  - With `E`=0: stay in IDLE.
- XFER:
  - Each cycle accesses the byte at `(base+cnt) mod 256`. The address wraps at 255→0.
  - Store: writes `DI[31-8*cnt -: 8]` at the edge. A byte store writes `DI[7:0]`.
  - Load: shifts the read byte into a 32-bit staging register.
  - Word access: `cnt` runs 0..3, then goes to DONE. Byte access: only `cnt`=0, then goes to DONE.
- DONE:
  - `Done`=1 for exactly this one cycle.
  - If the access was a load, `DO` was updated at the edge entering DONE. A word load gives the staged word; a byte load gives `{24'b0, byte}`.
  - Always returns to IDLE at the next edge.
- `DO` holds its value across stores and idle cycles. Only a completed load changes it.
- `Stall` = `E` && state != DONE (combinational). The pipeline therefore advances on the DONE edge, and the next instruction is in EX/MEM when the FSM re-enters IDLE.
- Changes on `E`, `A` or `DI` after acceptance are ignored, because the operands are latched.

## Timing
- Reset values: state = IDLE, `cnt` = 0, `DO` = 0, `Done` = 0, `Fault` = 0. `Stall` is then 0 unless `E`=1.
- Word access:
  - Cycle c0 is IDLE with `E`=1 and `Stall`=1.
  - c1–c4 are XFER, with `Stall`=1.
  - c5 is DONE, with `Done`=1 and `Stall`=0.
  - Stall is 5 cycles in total.
- Byte access: c0 IDLE, c1 XFER, c2 DONE. Stall is 2 cycles.
- Back-to-back requests: the second request is accepted in the IDLE cycle that follows DONE. There is one dead cycle between accesses.
- `Clr` in any state returns to IDLE at that edge and clears `DO`. Bytes already written by a partial word store remain written.
- Memory read is asynchronous inside the array and write is synchronous. A byte is visible to a later access in the cycle after it is written.

## Configuration
- Macro: `MEM_ALIGN_CHECK_EN`.
- Defined:
  - A word access with `A[1:0]` != 0 skips XFER and goes IDLE→DONE.
  - `Fault`=1 and `Done`=1 in that DONE cycle.
  - Memory and `DO` are unchanged. Stall lasts 1 cycle.
- Undefined:
  - Misaligned words proceed normally with address wrap.
  - `Fault` is tied to 0.

## Structure
- A shared include file holds:
  - state encodings `ST_IDLE`, `ST_XFER` and `ST_DONE`;
  - `SIZE_WORD`=0 and `SIZE_BYTE`=1;
  - `RW_LOAD`=0 and `RW_STORE`=1;
  - `MEM_DEPTH`=256.
- One sub-module, `byte_ram`: 256×8, single port, synchronous write enable, asynchronous read. It holds `Mem` and is instantiated once.
- The FSM, counter, staging register and output registers live in the top module.

## Test plan
- Reset, then idle with `E`=0 for 3 cycles → `DO`=0, `Stall`=0, `Done`=0, memory untouched.
- Preload `Mem[8..11]`=`8'h11,8'h22,8'h33,8'h44`; word load at `A`=8 → `Stall` high c0–c4; `Done` in c5; `DO`=`32'h11223344`.
- Word store `DI`=`32'hDEADBEEF` at `A`=`32'h0000_0110`, then byte load at 0x12 → `Mem[0x10..0x13]`=`DE,AD,BE,EF`; `DO`=`32'h000000BE`; byte load stall = 2 cycles.
- Word store at `A`=0xFE (macro undefined) → writes `Mem[FE]`,`Mem[FF]`,`Mem[00]`,`Mem[01]` in that order. With `MEM_ALIGN_CHECK_EN`: `Fault`=1, nothing written, stall = 1 cycle.
- Assert `Clr` during the third XFER cycle of a word store to 0x20 → FSM returns to IDLE and `DO`=0. `Mem[0x20]` and `Mem[0x21]` are written; `Mem[0x22]` and `Mem[0x23]` keep their old values.
- Two back-to-back byte loads with `E` held high → two `Done` pulses three cycles apart; `DO` updates on each.
